ahb_psram_controller: RTL and testbench
=======================================

AHB_PSRAM_CONTROLLER -- requirements
Module: ahb_psram_controller

Interface
REQ-001 SHALL have no parameters; fixed constants only (see Structure).
REQ-002 HCLK  in  1  single clock; all logic on rising edge.
REQ-003 HRESET  in  1  synchronous, active-high reset.
REQ-004 HSEL  in  1  AHB-Lite slave select.
REQ-005 HADDR  in  32  byte address; bits [23:0] used.
REQ-006 HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ (valid transfer).
REQ-007 HWRITE  in  1  1 means write.
REQ-008 HSIZE  in  3  0 = byte, 1 = half, 2 = word.
REQ-009 HWDATA  in  32  write data, valid in the data phase.
REQ-010 HREADY  in  1  bus ready (system HREADY).
REQ-011 HREADYOUT  out  1  slave ready.
REQ-012 HRDATA  out  32  read data.
REQ-013 sck  out  1  PSRAM serial clock.
REQ-014 ce_n  out  1  PSRAM chip enable, active low.
REQ-015 din  in  4  PSRAM data in.
REQ-016 dout  out  4  PSRAM data out.
REQ-017 douten  out  4  per-bit output enable; all four bits always equal.

Function
REQ-018 A transfer SHALL start when HSEL & HTRANS[1] & HREADY are high at an HCLK edge; HADDR, HWRITE and HSIZE are latched at that edge.
REQ-019 HREADYOUT SHALL go low on the next cycle and stay low until the PSRAM transaction completes; it returns high for exactly the final data-phase cycle.
REQ-020 For writes, HWDATA SHALL be captured on the first data-phase cycle.
REQ-021 Byte count N SHALL be 1, 2 or 4 for HSIZE 0, 1 or 2 respectively.
REQ-022 Lane mapping SHALL be little-endian: byte i (i = 0..N-1) uses lane (HADDR[1:0]+i) mod 4.
REQ-023 Memory order SHALL be lowest address first; within each byte the high nibble goes first.
REQ-024 sck SHALL idle low and toggle every HCLK while ce_n is low (sck period = 2 HCLK).
REQ-025 dout SHALL change on sck falling edges; din SHALL be sampled on sck rising edges.
REQ-026 State machine SHALL be IDLE -> CMD (8 sck) -> ADDR (6 sck) -> [read only: WAIT, 6 sck] -> DATA (2N sck) -> DONE -> IDLE.
REQ-027 CMD state: 8-bit command sent MSB first on dout[0]; dout[3:1] = 0; douten = 4'hF.
REQ-028 Write command SHALL be 0x38; read command SHALL be 0xEB.
REQ-029 ADDR state: 24-bit address sent as 6 nibbles, MSB first, on dout[3:0]; douten = 4'hF.
REQ-030 WAIT state: douten SHALL be 0 (bus released).
REQ-031 DATA state, write: douten SHALL be 4'hF.
REQ-032 DATA state, read: douten SHALL be 0; nibbles assemble into the HRDATA lanes; unused lanes read 0.
REQ-033 DONE state: ce_n SHALL go high, sck SHALL be low, and ce_n SHALL stay high for at least 1 HCLK before the next command.
REQ-034 HRDATA SHALL hold its last read value until the next read completes.
REQ-035 A new address phase SHALL only be accepted while HREADYOUT = 1.
REQ-036 IDLE, SEQ and BUSY transfers with HSEL = 0 SHALL be ignored with zero wait states.

Reset
REQ-037 While HRESET is high, the outputs SHALL be: HREADYOUT = 1, HRDATA = 0, ce_n = 1, sck = 0, dout = 0, douten = 0; the FSM SHALL be IDLE.
REQ-038 Reset asserted mid-transaction SHALL abort at the next edge: ce_n goes high and no partial write is retried.

Structure
REQ-039 A shared package SHALL hold the command codes (0x38, 0xEB), the wait count (6), the address nibble count (6) and the FSM state encoding.
REQ-040 The design SHALL use one sub-module, psram_qspi_engine: a bit/nibble serializer and FSM with a start/done handshake.
REQ-041 The top level SHALL contain the AHB front end: address-phase latch, lane mapping and HREADYOUT generation.

Verification
REQ-042 Word write 0x0 = 0xABCD1234, then word read 0x0 -> HRDATA = 0xABCD1234; bytes on dio after the address: 34, 12, CD, AB.
REQ-043 Byte read at 0x2 after REQ-042 -> HRDATA[23:16] = 0xCD, other lanes 0.
REQ-044 Word write 0x64 = 0x88776655, then word read -> 0x88776655.
REQ-045 Half read at 0x64 -> 0x00006655; half read at 0x65 -> 0x00776600.
REQ-046 Word-read timing: ce_n low for exactly 8+6+6+8 = 28 sck periods; the first sck rise carries cmd bit7 = 0 of 0xEB... correction: bit7 of 0xEB = 1 on dout[0].
REQ-047 HRESET pulsed mid-read -> ce_n = 1 and HREADYOUT = 1 on the next edge; a subsequent read returns correct data.

Source files
------------

// File: rtl/ahb_psram_controller_pkg.sv
// Shared constants and FSM encoding for the AHB-to-QSPI PSRAM controller.
package ahb_psram_controller_pkg;

  localparam logic [7:0]  CmdWrite    = 8'h38;
  localparam logic [7:0]  CmdRead     = 8'hEB;
  localparam int unsigned CmdBits     = 8;
  localparam int unsigned AddrNibbles = 6;
  localparam int unsigned WaitCycles  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StWait,
    StData,
    StDone
  } psram_state_e;

  function automatic logic [2:0] size_to_bytes(input logic [2:0] hsize);
    case (hsize)
      3'd0:    return 3'd1;
      3'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/psram_qspi_engine.sv
// QSPI serializer/FSM: command on dio[0], address and data as nibbles, start/done handshake.
module psram_qspi_engine
  import ahb_psram_controller_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [23:0] addr,
  input  logic [2:0]  nbytes,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        sck,
  output logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic [3:0]  douten
);

  psram_state_e state_q;
  logic         sck_q, ce_n_q, done_q, wr_q;
  logic [3:0]   dout_q, douten_q, cnt_q, data_last;
  logic [2:0]   nb_q;
  logic [31:0]  sr_q, rd_q;

  assign data_last = {nb_q, 1'b0} - 4'd1;

  // sr_q holds the bits still to be sent; the current bit/nibble is already in dout_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sck_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      done_q   <= 1'b0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      douten_q <= '0;
      cnt_q    <= '0;
      nb_q     <= '0;
      sr_q     <= '0;
      rd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StCmd;
            ce_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            douten_q <= 4'hF;
            dout_q   <= {3'b000, write ? CmdWrite[7] : CmdRead[7]};
            sr_q     <= write ? {CmdWrite[6:0], addr, 1'b0} : {CmdRead[6:0], addr, 1'b0};
            cnt_q    <= '0;
            wr_q     <= write;
            nb_q     <= nbytes;
            rd_q     <= '0;
          end
        end
        StDone: state_q <= StIdle;
        default: begin
          if (!sck_q) begin
            sck_q <= 1'b1;
            if (state_q == StData && !wr_q) rd_q <= {rd_q[27:0], din};
          end else begin
            sck_q <= 1'b0;
            cnt_q <= cnt_q + 4'd1;
            case (state_q)
              StCmd: begin
                if (cnt_q == 4'(CmdBits - 1)) begin
                  state_q <= StAddr;
                  cnt_q   <= '0;
                  dout_q  <= sr_q[31:28];
                  sr_q    <= sr_q << 4;
                end else begin
                  dout_q <= {3'b000, sr_q[31]};
                  sr_q   <= sr_q << 1;
                end
              end
              StAddr: begin
                if (cnt_q == 4'(AddrNibbles - 1)) begin
                  cnt_q <= '0;
                  if (wr_q) begin
                    state_q <= StData;
                    dout_q  <= wdata[31:28];
                    sr_q    <= wdata << 4;
                  end else begin
                    state_q  <= StWait;
                    dout_q   <= '0;
                    douten_q <= '0;
                  end
                end else begin
                  dout_q <= sr_q[31:28];
                  sr_q   <= sr_q << 4;
                end
              end
              StWait: begin
                if (cnt_q == 4'(WaitCycles - 1)) begin
                  state_q <= StData;
                  cnt_q   <= '0;
                end
              end
              StData: begin
                if (cnt_q == data_last) begin
                  state_q  <= StDone;
                  ce_n_q   <= 1'b1;
                  dout_q   <= '0;
                  douten_q <= '0;
                  done_q   <= 1'b1;
                end else if (wr_q) begin
                  dout_q <= sr_q[31:28];
                  sr_q   <= sr_q << 4;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign rdata  = rd_q;
  assign done   = done_q;
  assign sck    = sck_q;
  assign ce_n   = ce_n_q;
  assign dout   = dout_q;
  assign douten = douten_q;

endmodule

// File: rtl/ahb_psram_controller.sv
// AHB-Lite slave front end for a QSPI PSRAM: address-phase latch, byte lanes, wait states.
module ahb_psram_controller
  import ahb_psram_controller_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        sck,
  output logic        ce_n,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic [3:0]  douten
);

  logic        hreadyout_q, write_q, pend_q, start_q, accept, eng_done;
  logic [23:0] addr_q;
  logic [2:0]  size_q, nbytes;
  logic [31:0] wdata_q, hrdata_q, wstream, rd_raw, rd_lanes;
  logic [1:0]  lane;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:24], HTRANS[0]};
  assign accept      = HSEL & HTRANS[1] & HREADY & hreadyout_q;
  assign nbytes      = size_to_bytes(size_q);

  // Byte i of a transfer lives in lane (addr+i) mod 4; the stream is sent first byte first.
  always_comb begin
    wstream  = '0;
    rd_lanes = '0;
    lane     = '0;
    for (int i = 0; i < 4; i++) begin
      lane = addr_q[1:0] + i[1:0];
      wstream[8*(3-i) +: 8] = wdata_q[8*lane +: 8];
      if (i < int'(nbytes)) rd_lanes[8*lane +: 8] = rd_raw[8*(int'(nbytes)-1-i) +: 8];
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      hreadyout_q <= 1'b1;
      hrdata_q    <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      pend_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (accept) begin
        addr_q      <= HADDR[23:0];
        write_q     <= HWRITE;
        size_q      <= HSIZE;
        hreadyout_q <= 1'b0;
        pend_q      <= 1'b1;
      end
      if (pend_q) begin
        wdata_q <= HWDATA;
        start_q <= 1'b1;
        pend_q  <= 1'b0;
      end
      if (eng_done) begin
        hreadyout_q <= 1'b1;
        if (!write_q) hrdata_q <= rd_lanes;
      end
    end
  end

  psram_qspi_engine u_engine (
    .clk    (HCLK),
    .rst    (HRESET),
    .start  (start_q),
    .write  (write_q),
    .addr   (addr_q),
    .nbytes (nbytes),
    .wdata  (wstream),
    .rdata  (rd_raw),
    .done   (eng_done),
    .sck    (sck),
    .ce_n   (ce_n),
    .din    (din),
    .dout   (dout),
    .douten (douten)
  );

  assign HREADYOUT = hreadyout_q;
  assign HRDATA    = hrdata_q;

endmodule

// File: tb/tb_ahb_psram_controller.sv
// Scoreboard bench: AHB stimulus pushes expectations, a monitor checks each completed transfer.
module tb_ahb_psram_controller;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd0;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        sck, ce_n;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout, douten;

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  ahb_psram_controller dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .sck       (sck),
    .ce_n      (ce_n),
    .din       (din),
    .dout      (dout),
    .douten    (douten)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  cmd;
    logic [23:0] addr;
    int          periods;
    logic [31:0] wstream;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // PSRAM model: 256-byte memory, commands decoded from the serial stream.
  logic [7:0]  mem [0:255];
  int          bitcnt = 0;
  int          proto_err = 0;
  int          j;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_adr = '0;
  logic [31:0] m_wstream = '0;
  logic [3:0]  exp_oe;
  logic [7:0]  rb;

  always @(negedge ce_n) begin
    bitcnt = 0; m_cmd = '0; m_adr = '0; m_wstream = '0; proto_err = 0;
  end

  always @(posedge sck) begin
    if (ce_n === 1'b0) begin
      if (bitcnt < 8) begin
        m_cmd = {m_cmd[6:0], dout[0]};
        if (dout[3:1] !== 3'b000) proto_err++;
        exp_oe = 4'hF;
      end else if (bitcnt < 14) begin
        m_adr  = {m_adr[19:0], dout};
        exp_oe = 4'hF;
      end else if (m_cmd == 8'h38) begin
        exp_oe    = 4'hF;
        m_wstream = {m_wstream[27:0], dout};
        if ((bitcnt - 14) % 2 == 1) mem[m_adr[7:0] + 8'((bitcnt - 14) / 2)] = m_wstream[7:0];
      end else begin
        exp_oe = 4'h0;
      end
      if (douten !== exp_oe) proto_err++;
      bitcnt++;
    end
  end

  always @(negedge sck) begin
    if (ce_n === 1'b0 && bitcnt >= 20 && m_cmd == 8'hEB) begin
      j   = bitcnt - 20;
      rb  = mem[m_adr[7:0] + 8'(j / 2)];
      din = (j % 2 == 0) ? rb[7:4] : rb[3:0];
    end
  end

  // Monitor: a low-to-high HREADYOUT marks the final data-phase cycle of a transfer.
  logic prev_rdy = 1'b1;
  always @(negedge HCLK) begin
    if (HRESET) begin
      prev_rdy = 1'b1;
    end else begin
      if (!prev_rdy && HREADYOUT) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_completion: got a completion, expected none");
        end else begin
          mon_e = sbq.pop_front();
          check("hrdata", HRDATA, mon_e.rdata);
          check("cmd", {24'h0, m_cmd}, {24'h0, mon_e.cmd});
          check("addr", {8'h0, m_adr}, {8'h0, mon_e.addr});
          check("sck_periods", bitcnt, mon_e.periods);
          check("bus_protocol_errors", proto_err, 0);
          if (mon_e.cmd == 8'h38) check("write_stream", m_wstream, mon_e.wstream);
        end
      end
      prev_rdy = HREADYOUT;
    end
  end

  task automatic ahb(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                     input logic [31:0] wdata, input exp_t e);
    int n;
    sbq.push_back(e);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HSIZE = size;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
    n = 0;
    while (HREADYOUT !== 1'b1 && n < 200) begin
      @(negedge HCLK);
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL timeout: HREADYOUT still %b, expected 1", HREADYOUT);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge HCLK);
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_ce_n", {31'h0, ce_n}, 32'h1);
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_dout", {28'h0, dout}, 32'h0);
    check("rst_douten", {28'h0, douten}, 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    ahb(1'b1, 32'h0,  3'd2, 32'hABCD1234, exp_t'{32'h0,        8'h38, 24'h0,  22, 32'h3412CDAB});
    ahb(1'b0, 32'h0,  3'd2, 32'h0,        exp_t'{32'hABCD1234, 8'hEB, 24'h0,  28, 32'h0});
    ahb(1'b0, 32'h2,  3'd0, 32'h0,        exp_t'{32'h00CD0000, 8'hEB, 24'h2,  22, 32'h0});
    ahb(1'b1, 32'h64, 3'd2, 32'h88776655, exp_t'{32'h00CD0000, 8'h38, 24'h64, 22, 32'h55667788});
    ahb(1'b0, 32'h64, 3'd2, 32'h0,        exp_t'{32'h88776655, 8'hEB, 24'h64, 28, 32'h0});
    ahb(1'b0, 32'h64, 3'd1, 32'h0,        exp_t'{32'h00006655, 8'hEB, 24'h64, 24, 32'h0});
    ahb(1'b0, 32'h65, 3'd1, 32'h0,        exp_t'{32'h00776600, 8'hEB, 24'h65, 24, 32'h0});
    ahb(1'b1, 32'h3,  3'd0, 32'h5A000000, exp_t'{32'h00776600, 8'h38, 24'h3,  16, 32'h0000005A});
    ahb(1'b0, 32'h0,  3'd2, 32'h0,        exp_t'{32'h5ACD1234, 8'hEB, 24'h0,  28, 32'h0});

    // Unselected or non-transfer cycles must not stall the bus or touch the PSRAM.
    for (int k = 0; k < 3; k++) begin
      HSEL   = (k != 0);
      HTRANS = (k == 0) ? 2'b10 : (k == 1) ? 2'b00 : 2'b01;
      HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'd2;
      @(negedge HCLK);
      check("ignored_hreadyout", {31'h0, HREADYOUT}, 32'h1);
      check("ignored_ce_n", {31'h0, ce_n}, 32'h1);
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);
    check("ignored_no_start", {31'h0, ce_n}, 32'h1);

    // Abort a word read partway through with a reset pulse.
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h64; HWRITE = 1'b0; HSIZE = 3'd2;
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    n = 0;
    while (ce_n !== 1'b0 && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    repeat (12) @(negedge HCLK);
    check("abort_ce_n_active", {31'h0, ce_n}, 32'h0);
    HRESET = 1'b1;
    @(negedge HCLK);
    check("abort_ce_n", {31'h0, ce_n}, 32'h1);
    check("abort_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("abort_sck", {31'h0, sck}, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);

    ahb(1'b0, 32'h64, 3'd2, 32'h0,        exp_t'{32'h88776655, 8'hEB, 24'h64, 28, 32'h0});

    repeat (5) @(negedge HCLK);
    check("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
